// File: rtl/cdc_pulse_multi.sv
// cdc_pulse_multi: per-channel level synchroniser into the oclk domain with
// edge pulses, sticky event flags and overrun detection.
// Optional per-channel saturating event counters: define CDC_PULSE_MULTI_COUNT_EN.
// Channels are independent; never pass a multi-bit bus through this block.
module cdc_pulse_multi #(
  parameter int unsigned          CHANNELS    = 1,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0]  RISE_EN     = '1,
  parameter logic [CHANNELS-1:0]  FALL_EN     = '1,
  parameter int unsigned          COUNT_W     = 8
) (
  input  logic                        oclk,
  input  logic                        orst,
  input  logic [CHANNELS-1:0]         i,
  input  logic [CHANNELS-1:0]         clr,
  output logic [CHANNELS-1:0]         opulse,
  output logic [CHANNELS-1:0]         odata,
  output logic [CHANNELS-1:0]         osticky,
`ifdef CDC_PULSE_MULTI_COUNT_EN
  output logic [CHANNELS-1:0]         oovr,
  output logic [CHANNELS*COUNT_W-1:0] ocount
`else
  output logic [CHANNELS-1:0]         oovr
`endif
);

  localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);

  // Synchroniser depth below two is not a valid CDC structure.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("cdc_pulse_multi: SYNC_STAGES must be >= 2");
  end

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                               state_q;
  state_t                               state_d;
  logic [PRIME_W-1:0]                   prime_cnt_q;
  logic                                 run_c;
  logic                                 prime_inc_c;

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  s_last;
  logic [CHANNELS-1:0]                  rise;
  logic [CHANNELS-1:0]                  fall;
  logic [CHANNELS-1:0]                  ev;

  // FSM state register; reset always returns to priming.
  always_ff @(posedge oclk or posedge orst) begin
    if (orst) begin
      state_q <= ST_PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave PRIME on the (SYNC_STAGES+1)th edge after reset release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PRIME: begin
        if (prime_cnt_q == PRIME_W'(SYNC_STAGES)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_PRIME;
    endcase
  end

  // FSM decoded controls: event qualification enable and prime counter step.
  always_comb begin
    run_c       = 1'b0;
    prime_inc_c = 1'b0;
    case (state_q)
      ST_PRIME: prime_inc_c = 1'b1;
      ST_RUN:   run_c       = 1'b1;
      default: begin
        run_c       = 1'b0;
        prime_inc_c = 1'b0;
      end
    endcase
  end

  // Counts edges spent priming so pre-existing levels never raise events.
  always_ff @(posedge oclk or posedge orst) begin
    if (orst) begin
      prime_cnt_q <= '0;
    end else if (prime_inc_c) begin
      prime_cnt_q <= prime_cnt_q + PRIME_W'(1);
    end
  end

  // Synchroniser chain, one column per channel.
  always_ff @(posedge oclk or posedge orst) begin
    if (orst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Edge detect against the registered copy and qualify per channel.
  always_comb begin
    s_last = sync_q[SYNC_STAGES-1];
    rise   = s_last & ~odata;
    fall   = ~s_last & odata;
    ev     = {CHANNELS{run_c}} & ((rise & RISE_EN) | (fall & FALL_EN));
  end

  // Registered data copy and pulse update together so they stay aligned.
  always_ff @(posedge oclk or posedge orst) begin
    if (orst) begin
      odata  <= '0;
      opulse <= '0;
    end else begin
      odata  <= s_last;
      opulse <= ev;
    end
  end

  // Sticky and overrun flags; a clear coincident with an event keeps the event.
  always_ff @(posedge oclk or posedge orst) begin
    if (orst) begin
      osticky <= '0;
      oovr    <= '0;
    end else begin
      osticky <= ev | (osticky & ~clr);
      oovr    <= (ev & osticky & ~clr) | (oovr & ~clr);
    end
  end

`ifdef CDC_PULSE_MULTI_COUNT_EN
  logic [CHANNELS-1:0][COUNT_W-1:0] cnt_q;

  // Saturating per-channel event counters; clear with an event restarts at 1.
  always_ff @(posedge oclk or posedge orst) begin
    if (orst) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (clr[c]) begin
          cnt_q[c] <= ev[c] ? COUNT_W'(1) : '0;
        end else if (ev[c] && (cnt_q[c] != {COUNT_W{1'b1}})) begin
          cnt_q[c] <= cnt_q[c] + COUNT_W'(1);
        end
      end
    end
  end

  assign ocount = cnt_q;
`endif

endmodule
